muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for MULT/DIV. Sits between the control unit and the HI/LOW registers.
//  Accepts one operation per start pulse and iterates a radix-2 shift-add multiply or a restoring divide.
//  Presents a 64-bit result as hi/lo with a one-cycle done pulse. Flags divide-by-zero for the exception path.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous, active-low; reset==0 at a rising edge clears all state
//  start     in   1      launch request; sampled only in IDLE
//  op        in   2      00 MULT, 01 DIV, 10 MULTU, 11 DIVU (op[1] see CONFIGURATION)
//  a         in   WIDTH  multiplicand / dividend, sampled with start
//  b         in   WIDTH  multiplier / divisor, sampled with start
//  busy      out  1      high while an operation is in flight
//  done      out  1      one-cycle pulse; hi/lo valid from this cycle
//  div_zero  out  1      one-cycle pulse with done when DIV/DIVU has b==0
//  hi        out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo        out  WIDTH  MULT: product[W-1:0]; DIV: quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, div_zero = 0; hi, lo = 0; internal accumulators = 0.
//  States: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
//  Cycle 0 = the edge that samples start=1 in IDLE.
//   Operands are latched at that edge. Signed ops also latch operand signs and take absolute values.
//  busy=1 in cycles 1..WIDTH+1. Cycles 1..WIDTH run RUN, one iteration per cycle; cycle WIDTH+1 runs FIX.
//  FIX applies signs:
//   product negated if signs differ
//   quotient negated if signs differ
//   remainder takes the dividend's sign
//  Cycle WIDTH+2 (34 for WIDTH=32): done=1, busy=0, hi/lo updated.
//   hi/lo then hold until the next done or reset.
//  Divide by zero: start with DIV/DIVU and b==0 -> no RUN.
//   Cycle 1: done=1, div_zero=1, busy=0; hi/lo unchanged.
//  Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no flag).
//  Absolute values are computed in WIDTH+1 bits so |-2^(W-1)| is exact.
//  start while busy or in DONE: ignored, not queued. A start in the cycle after done is accepted.
//  op, a, b may change after cycle 0 without effect.
//  Reset low mid-operation: at that edge, return to IDLE with all outputs 0; no done is issued.
//  The control unit holds its MULT/DIV state until done, then writes HI/LOW from hi/lo.
// CONFIGURATION
//  MULDIV_UNSIGNED_EN defined: op[1]=1 selects unsigned MULTU/DIVU; FIX sign correction is skipped.
//  Not defined: op[1] is ignored and every op is treated as signed MULT/DIV; sign logic is always active.
// STRUCTURE
//  Shared package muldiv_pkg holds:
//   state encoding localparams S_IDLE, S_RUN, S_FIX, S_DONE
//   op codes OP_MULT=2'b00, OP_DIV=2'b01, OP_MULTU=2'b10, OP_DIVU=2'b11
//   the control-unit HI/LOW write-select constant
//  One sub-module, muldiv_signfix: combinational abs-value and sign-restore logic, used in load and FIX.
//  Iteration counter is clog2(WIDTH)+1 bits. Multiply and divide share one 2W+1-bit accumulator.
// TESTING
//  1. MULT a=7, b=0xFFFFFFFD -> cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly cycles 1..33.
//  2. DIV a=0xFFFFFFF9 (-7), b=2 -> cycle 34: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
//  3. DIV a=5, b=0 with hi/lo preloaded from test 2 -> cycle 1: done=1, div_zero=1; hi/lo unchanged; busy never high.
//  4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  5. Start MULT 3*4, pulse start with DIV at cycle 5 -> ignored, result hi=0, lo=12 at cycle 34.
//     Repeat with reset=0 at cycle 10 -> cycle 11: busy=0, hi=lo=0, no done ever.
//  6. op=MULTU a=0xFFFFFFFF, b=2:
//     with MULDIV_UNSIGNED_EN -> hi=1, lo=0xFFFFFFFE;
//     without it -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle MULT/DIV sequencer and its helpers.
//  - state_t       : sequencer FSM states (S_IDLE, S_RUN, S_FIX, S_DONE)
//  - OP_*          : op codes presented by the control unit
//  - HILO_WSEL_BOTH: write-select the control unit uses to load HI and LOW
//                    together from hi/lo when done pulses
//  - op_is_div()   : decodes the divide bit of an op code
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Bit 1 selects HI, bit 0 selects LOW; a finished MULT/DIV writes both.
    localparam logic [1:0] HILO_WSEL_BOTH = 2'b11;

    // op[0] distinguishes divide from multiply in both signed and unsigned forms.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// ---------------------------------------------------------------------------
// muldiv_signfix
// Combinational sign handling for the MULT/DIV sequencer.
//  Load side : converts the raw operands into magnitudes (WIDTH+1 bits so that
//              the most negative value has an exact magnitude) and reports
//              which operands were negative.
//  Fix side  : restores signs on the finished magnitude result.
//              product  -> negated when operand signs differ
//              quotient -> negated when operand signs differ
//              remainder-> takes the dividend's sign
// Ports
//  a, b       in  WIDTH     raw operands
//  signed_op  in  1         treat operands as two's complement
//  a_mag      out WIDTH+1   |a|
//  b_mag      out WIDTH+1   |b|
//  a_neg      out 1         a is negative (only when signed_op)
//  b_neg      out 1         b is negative (only when signed_op)
//  raw        in  2*WIDTH   unsigned result: product, or {remainder, quotient}
//  is_div     in  1         raw holds a divide result
//  sign_a     in  1         latched sign of a
//  sign_b     in  1         latched sign of b
//  fix_hi     out WIDTH     signed-corrected hi word
//  fix_lo     out WIDTH     signed-corrected lo word
// ---------------------------------------------------------------------------
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic [WIDTH:0]     a_mag,
    output logic [WIDTH:0]     b_mag,
    output logic               a_neg,
    output logic               b_neg,
    input  logic [2*WIDTH-1:0] raw,
    input  logic               is_div,
    input  logic               sign_a,
    input  logic               sign_b,
    output logic [WIDTH-1:0]   fix_hi,
    output logic [WIDTH-1:0]   fix_lo
);

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Operand magnitudes: sign-extend to WIDTH+1 bits before negating so that
    // the most negative input yields its true positive magnitude.
    always_comb begin
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? ({(WIDTH+1){1'b0}} - {a[WIDTH-1], a}) : {1'b0, a};
        b_mag = b_neg ? ({(WIDTH+1){1'b0}} - {b[WIDTH-1], b}) : {1'b0, b};
    end

    // Result sign restoration. Unsigned ops latch both signs as zero, so no
    // negation happens for them without any extra gating here.
    always_comb begin
        prod_fixed = (sign_a ^ sign_b) ? ({(2*WIDTH){1'b0}} - raw) : raw;
        quo_fixed  = (sign_a ^ sign_b) ? ({WIDTH{1'b0}} - raw[WIDTH-1:0])
                                       : raw[WIDTH-1:0];
        rem_fixed  = sign_a ? ({WIDTH{1'b0}} - raw[2*WIDTH-1:WIDTH])
                            : raw[2*WIDTH-1:WIDTH];
        if (is_div) begin
            fix_hi = rem_fixed;
            fix_lo = quo_fixed;
        end else begin
            fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
            fix_lo = prod_fixed[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MULT/DIV engine between the control unit and the HI/LOW
// registers. One start pulse in IDLE launches a radix-2 shift-add multiply or
// a restoring divide over WIDTH iterations, followed by a sign-fix cycle and a
// one-cycle done pulse. Divide by zero skips the iterations and reports
// div_zero alongside done, leaving hi/lo untouched.
// Configuration macro: MULDIV_UNSIGNED_EN
//  defined     : op[1]=1 selects unsigned MULTU/DIVU (no sign correction)
//  not defined : op[1] is ignored, every op is signed
// Ports
//  clk       in  1      rising-edge clock
//  reset     in  1      synchronous, active-low; clears all state
//  start     in  1      launch request, honoured only in IDLE
//  op        in  2      00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//  a         in  WIDTH  multiplicand / dividend
//  b         in  WIDTH  multiplier / divisor
//  busy      out 1      operation in flight (RUN and FIX)
//  done      out 1      one-cycle pulse, hi/lo valid from this cycle
//  div_zero  out 1      pulses with done for a divide by zero
//  hi        out WIDTH  product high word / remainder
//  lo        out WIDTH  product low word / quotient
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH + 1;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [WIDTH:0]   operand;
    logic             is_div_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             dz_r;

    logic             signed_op;
    logic             b_zero;
    logic             last_iter;
    logic [WIDTH:0]   a_mag;
    logic [WIDTH:0]   b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [ACC_W-1:0] mul_next;
    logic [ACC_W-1:0] div_next;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_op = ~op[1];
`else
    logic unused_op_bit;
    assign signed_op     = 1'b1;
    assign unused_op_bit = op[1];
`endif

    assign b_zero    = (b == {WIDTH{1'b0}});
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .a        (a),
        .b        (b),
        .signed_op(signed_op),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .a_neg    (a_neg),
        .b_neg    (b_neg),
        .raw      (acc[2*WIDTH-1:0]),
        .is_div   (is_div_r),
        .sign_a   (sign_a_r),
        .sign_b   (sign_b_r),
        .fix_hi   (fix_hi),
        .fix_lo   (fix_lo)
    );

    // One iteration of each algorithm on the shared accumulator.
    // Multiply: {partial product, multiplier}; add on lsb, then shift right.
    // Divide:   {remainder, dividend/quotient}; shift left, trial-subtract,
    //           shift in a quotient bit of 1 when the subtraction fits.
    always_comb begin
        mul_sum   = acc[0] ? (acc[2*WIDTH:WIDTH] + operand) : acc[2*WIDTH:WIDTH];
        mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        if (rem_shift >= operand) begin
            div_next = {rem_shift - operand, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift, acc[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A divide by zero jumps straight to DONE; starts seen
    // outside IDLE are simply not looked at.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (op_is_div(op) && b_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy     = (state == S_RUN) || (state == S_FIX);
        done     = (state == S_DONE);
        div_zero = (state == S_DONE) && dz_r;
    end

    // Datapath: operand capture on launch, iterations in RUN, result
    // write-back to hi/lo in FIX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            dz_r     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div_r <= op_is_div(op);
                        sign_a_r <= a_neg;
                        sign_b_r <= b_neg;
                        dz_r     <= op_is_div(op) && b_zero;
                        if (op_is_div(op)) begin
                            acc     <= {{(WIDTH+1){1'b0}}, a_mag[WIDTH-1:0]};
                            operand <= b_mag;
                        end else begin
                            acc     <= {{(WIDTH+1){1'b0}}, b_mag[WIDTH-1:0]};
                            operand <= a_mag;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= is_div_r ? div_next : mul_next;
                    count <= count + CNT_W'(1);
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed bench for muldiv_sequencer (WIDTH=32). Each launched operation
// pushes its hand-computed result onto a scoreboard; an independent monitor
// pops and compares whenever done is seen, also checking latency from the
// launch edge and how many cycles busy was high. Expected values for MULTU
// depend on MULDIV_UNSIGNED_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          latency;
        int          busy_cycles;
        int          start_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Launch one operation: start is held for exactly the launch edge, then
    // operands are scrambled to show they are not re-sampled.
    task automatic applyStimulus(input logic [1:0] op_v, input logic [31:0] a_v,
                                 input logic [31:0] b_v, input bit expect_it,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dz, input string name);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        @(posedge clk);
        if (expect_it) begin
            e.hi          = exp_hi;
            e.lo          = exp_lo;
            e.dz          = exp_dz;
            e.latency     = exp_dz ? 1 : 34;
            e.busy_cycles = exp_dz ? 0 : 33;
            e.start_cyc   = cyc;
            e.name        = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait (bounded) until the monitor has consumed every expected result.
    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_%s actual=no_done required=done", sb[0].name);
            sb.delete();
        end
    endtask

    // Monitor: samples on the falling edge, tracks busy cycles and compares
    // each done against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b0) begin
                busy_run = 0;
            end else if (busy === 1'b1) begin
                busy_run++;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done actual=done required=no_done hi=0x%0h lo=0x%0h",
                             hi, lo);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    checkOutput({e.name, "_div_zero"}, 64'(div_zero), 64'(e.dz));
                    checkOutput({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.latency));
                    checkOutput({e.name, "_busy_cycles"}, 64'(busy_run), 64'(e.busy_cycles));
                    checkOutput({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
                end
                busy_run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_div_zero", 64'(div_zero), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        // 7 * -3 = -21
        applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_7_m3");
        waitDone(60);
        // -7 / 2 = -3 rem -1 (launched the cycle after the previous done)
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        waitDone(60);
        // divide by zero keeps hi/lo from the previous result
        applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, "div_by_zero");
        waitDone(60);
        // 7 / -2 = -3 rem +1 (remainder follows the dividend)
        applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1,
                      32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
        waitDone(60);
        // most negative / -1 wraps
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                      32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow");
        waitDone(60);
        // (-2^31)^2 = 2^62
        applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1,
                      32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minmin");
        waitDone(60);

        // Start pulses while busy and during DONE must be ignored.
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b1,
                      32'h0000_0000, 32'h0000_000C, 1'b0, "mult_3_4");
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        waitDone(60);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd9;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // MULTU -1 * 2: unsigned only when the feature is built in.
`ifdef MULDIV_UNSIGNED_EN
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1,
                      32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu_ff_2");
`else
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "multu_ff_2");
`endif
        waitDone(60);

        // Reset mid-operation: outputs cleared next cycle, no done afterwards.
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, "mult_reset");
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_done", 64'(done), 64'd0);
        checkOutput("midreset_hi", 64'(hi), 64'd0);
        checkOutput("midreset_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("post_reset_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
